// File: rtl/tlb_storage_assoc_if.sv
// Lookup / refill / flush bus between the TLB control FSM (master) and
// the set-associative TLB storage array (slave).
interface tlb_storage_assoc_if #(
  parameter int NUM_WAYS = 4,
  parameter int VPN_W    = 20,
  parameter int PPN_W    = 20,
  parameter int PERM_W   = 2
);
  localparam int WAY_BITS = $clog2(NUM_WAYS);

  logic                lk_req;
  logic                lk_ready;
  logic [VPN_W-1:0]    lk_vpn;
  logic                rsp_valid;
  logic                rsp_hit;
  logic [WAY_BITS-1:0] rsp_way;
  logic [PPN_W-1:0]    rsp_ppn;
  logic [PERM_W-1:0]   rsp_perms;
  logic                wr_en;
  logic                wr_ready;
  logic [WAY_BITS-1:0] wr_way;
  logic [VPN_W-1:0]    wr_vpn;
  logic [PPN_W-1:0]    wr_ppn;
  logic [PERM_W-1:0]   wr_perms;
  logic                flush_req;
  logic                flush_busy;

  modport master (
    output lk_req, lk_vpn, wr_en, wr_way, wr_vpn, wr_ppn, wr_perms, flush_req,
    input  lk_ready, rsp_valid, rsp_hit, rsp_way, rsp_ppn, rsp_perms,
           wr_ready, flush_busy
  );

  modport slave (
    input  lk_req, lk_vpn, wr_en, wr_way, wr_vpn, wr_ppn, wr_perms, flush_req,
    output lk_ready, rsp_valid, rsp_hit, rsp_way, rsp_ppn, rsp_perms,
           wr_ready, flush_busy
  );
endinterface

// File: rtl/tlb_storage_assoc.sv
// N-way set-associative VPN->PPN store with saturating-age LRU and a one-set-per-cycle
// flush engine. Optional hit/miss counters are enabled with the macro TLB_STATS_EN.
module tlb_storage_assoc #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  parameter int VPN_W    = 20,
  parameter int PPN_W    = 20,
  parameter int PERM_W   = 2,
  parameter int AGE_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef TLB_STATS_EN
  input  logic               stat_clr,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses,
`endif
  tlb_storage_assoc_if.slave bus
);
  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int WAY_BITS = $clog2(NUM_WAYS);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state_q;
  logic [SET_BITS-1:0] flush_idx_q;
  logic                busy_q;
  logic                ready_q;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [AGE_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
  logic [VPN_W-1:0]    vpn_mem [NUM_SETS][NUM_WAYS];
  logic [PPN_W-1:0]    ppn_mem [NUM_SETS][NUM_WAYS];
  logic [PERM_W-1:0]   perm_mem[NUM_SETS][NUM_WAYS];

  logic [SET_BITS-1:0] lk_set;
  logic [SET_BITS-1:0] wr_set;
  logic                lk_fire;
  logic                wr_fire;
  logic                same_set;

  logic                hit_p0;
  logic [WAY_BITS-1:0] hit_way_p0;
  logic [WAY_BITS-1:0] way_p0;
  logic                inv_found;
  logic [WAY_BITS-1:0] inv_way;
  logic [WAY_BITS-1:0] old_way;
  logic [AGE_W-1:0]    old_age;

  logic                vld_p1;
  logic                hit_p1;
  logic [WAY_BITS-1:0] way_p1;
  logic [PPN_W-1:0]    ppn_p1;
  logic [PERM_W-1:0]   perms_p1;

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

  assign lk_set   = bus.lk_vpn[SET_BITS-1:0];
  assign wr_set   = bus.wr_vpn[SET_BITS-1:0];
  assign lk_fire  = bus.lk_req & ready_q;
  assign wr_fire  = bus.wr_en & ready_q;
  assign same_set = wr_fire && (wr_set == lk_set);

  // Stage p0: tag compare and victim pick on the pre-write contents of the set
  always_comb begin
    hit_p0     = 1'b0;
    hit_way_p0 = '0;
    inv_found  = 1'b0;
    inv_way    = '0;
    old_way    = '0;
    old_age    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit_p0 && valid_q[lk_set][w] && (vpn_mem[lk_set][w] == bus.lk_vpn)) begin
        hit_p0     = 1'b1;
        hit_way_p0 = WAY_BITS'(w);
      end
      if (!inv_found && !valid_q[lk_set][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
      if (age_q[lk_set][w] > old_age) begin
        old_age = age_q[lk_set][w];
        old_way = WAY_BITS'(w);
      end
    end
    way_p0 = hit_p0 ? hit_way_p0 : (inv_found ? inv_way : old_way);
  end

  // Stage p1: registered lookup response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      hit_p1   <= 1'b0;
      way_p1   <= '0;
      ppn_p1   <= '0;
      perms_p1 <= '0;
    end else begin
      vld_p1 <= lk_fire;
      if (lk_fire) begin
        hit_p1   <= hit_p0;
        way_p1   <= way_p0;
        ppn_p1   <= hit_p0 ? ppn_mem[lk_set][hit_way_p0] : '0;
        perms_p1 <= hit_p0 ? perm_mem[lk_set][hit_way_p0] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.flush_req) begin
            state_q     <= FLUSH;
            flush_idx_q <= '0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
          end
        end
        FLUSH: begin
          if (flush_idx_q == SET_BITS'(NUM_SETS - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            flush_idx_q <= flush_idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A write to the looked-up set owns the age update so other ways age only once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= '0;
      end
    end else if (state_q == FLUSH) begin
      valid_q[flush_idx_q] <= '0;
      for (int w = 0; w < NUM_WAYS; w++) age_q[flush_idx_q][w] <= '0;
    end else begin
      if (lk_fire && hit_p0 && !same_set) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_BITS'(w) == hit_way_p0) age_q[lk_set][w] <= '0;
          else if (valid_q[lk_set][w]) age_q[lk_set][w] <= age_inc(age_q[lk_set][w]);
        end
      end
      if (wr_fire) begin
        valid_q[wr_set][bus.wr_way] <= 1'b1;
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_BITS'(w) == bus.wr_way) age_q[wr_set][w] <= '0;
          else if (valid_q[wr_set][w]) age_q[wr_set][w] <= age_inc(age_q[wr_set][w]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      vpn_mem[wr_set][bus.wr_way]  <= bus.wr_vpn;
      ppn_mem[wr_set][bus.wr_way]  <= bus.wr_ppn;
      perm_mem[wr_set][bus.wr_way] <= bus.wr_perms;
    end
  end

`ifdef TLB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (stat_clr) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (vld_p1) begin
      if (hit_p1) stat_hits <= stat_hits + 32'd1;
      else        stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

  assign bus.lk_ready   = ready_q;
  assign bus.wr_ready   = ready_q;
  assign bus.flush_busy = busy_q;
  assign bus.rsp_valid  = vld_p1;
  assign bus.rsp_hit    = hit_p1;
  assign bus.rsp_way    = way_p1;
  assign bus.rsp_ppn    = ppn_p1;
  assign bus.rsp_perms  = perms_p1;
endmodule

// File: tb/tb_tlb_storage_assoc.sv
// Bench for tlb_storage_assoc: a plain-array reference model checked against the DUT every
// cycle, plus directed vectors with hand-computed results. Stats checks need TLB_STATS_EN.
module tb_tlb_storage_assoc;
  localparam int NS   = 16;
  localparam int NW   = 4;
  localparam int AMAX = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  tlb_storage_assoc_if #(.NUM_WAYS(NW), .VPN_W(20), .PPN_W(20), .PERM_W(2)) bus ();

`ifdef TLB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
  logic [31:0] m_hits = '0;
  logic [31:0] m_misses = '0;
`endif

  tlb_storage_assoc #(
    .NUM_SETS(NS), .NUM_WAYS(NW), .VPN_W(20), .PPN_W(20), .PERM_W(2), .AGE_W(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef TLB_STATS_EN
    .stat_clr   (stat_clr),
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses),
`endif
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference state
  bit          m_valid [NS][NW];
  int          m_age   [NS][NW];
  logic [19:0] m_vpn   [NS][NW];
  logic [19:0] m_ppn   [NS][NW];
  logic [1:0]  m_perm  [NS][NW];
  bit          m_busy = 1'b0;
  int          m_fidx = 0;
  bit          e_valid = 1'b0;
  bit          e_hit = 1'b0;
  int          e_way = 0;
  logic [19:0] e_ppn = '0;
  logic [1:0]  e_perms = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void m_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_age[s][w]   = 0;
      end
    m_busy  = 1'b0;
    m_fidx  = 0;
    e_valid = 1'b0;
    e_hit   = 1'b0;
    e_way   = 0;
    e_ppn   = '0;
    e_perms = '0;
`ifdef TLB_STATS_EN
    m_hits   = '0;
    m_misses = '0;
`endif
  endfunction

  function automatic int m_victim(input int s);
    int best = 0;
    for (int w = 0; w < NW; w++) if (!m_valid[s][w]) return w;
    for (int w = 1; w < NW; w++) if (m_age[s][w] > m_age[s][best]) best = w;
    return best;
  endfunction

  function automatic void m_touch(input int s, input int keep);
    for (int w = 0; w < NW; w++) begin
      if (w == keep) m_age[s][w] = 0;
      else if (m_valid[s][w]) m_age[s][w] = (m_age[s][w] >= AMAX) ? AMAX : m_age[s][w] + 1;
    end
  endfunction

  function automatic void m_edge();
    bit lk_fire, wr_fire, hit;
    int ls, ws, hw, ww;
`ifdef TLB_STATS_EN
    if (stat_clr) begin
      m_hits = '0;
      m_misses = '0;
    end else if (e_valid) begin
      if (e_hit) m_hits = m_hits + 32'd1;
      else m_misses = m_misses + 32'd1;
    end
`endif
    lk_fire = bus.lk_req && !m_busy;
    wr_fire = bus.wr_en && !m_busy;
    ls = int'(bus.lk_vpn[3:0]);
    ws = int'(bus.wr_vpn[3:0]);
    ww = int'(bus.wr_way);
    hit = 1'b0;
    hw = 0;
    e_valid = lk_fire;
    if (lk_fire) begin
      for (int w = 0; w < NW; w++)
        if (!hit && m_valid[ls][w] && m_vpn[ls][w] == bus.lk_vpn) begin
          hit = 1'b1;
          hw = w;
        end
      e_hit   = hit;
      e_way   = hit ? hw : m_victim(ls);
      e_ppn   = hit ? m_ppn[ls][hw] : '0;
      e_perms = hit ? m_perm[ls][hw] : '0;
    end
    if (m_busy) begin
      for (int w = 0; w < NW; w++) begin
        m_valid[m_fidx][w] = 1'b0;
        m_age[m_fidx][w] = 0;
      end
      m_fidx++;
      if (m_fidx == NS) m_busy = 1'b0;
    end else begin
      if (lk_fire && hit && !(wr_fire && ws == ls)) m_touch(ls, hw);
      if (wr_fire) begin
        m_touch(ws, ww);
        m_valid[ws][ww] = 1'b1;
        m_vpn[ws][ww]   = bus.wr_vpn;
        m_ppn[ws][ww]   = bus.wr_ppn;
        m_perm[ws][ww]  = bus.wr_perms;
      end
      if (bus.flush_req) begin
        m_busy = 1'b1;
        m_fidx = 0;
      end
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_clear();
      else m_edge();
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_valid));
        if (e_valid) begin
          chk("rsp_hit", 32'(bus.rsp_hit), 32'(e_hit));
          chk("rsp_way", 32'(bus.rsp_way), e_way);
          chk("rsp_ppn", 32'(bus.rsp_ppn), 32'(e_ppn));
          chk("rsp_perms", 32'(bus.rsp_perms), 32'(e_perms));
        end
        chk("flush_busy", 32'(bus.flush_busy), 32'(m_busy));
        chk("lk_ready", 32'(bus.lk_ready), 32'(!m_busy));
        chk("wr_ready", 32'(bus.wr_ready), 32'(!m_busy));
`ifdef TLB_STATS_EN
        chk("stat_hits", stat_hits, m_hits);
        chk("stat_misses", stat_misses, m_misses);
`endif
      end
    end
  end

  task automatic cyc(input bit lq, input logic [19:0] lv, input bit we, input int ww,
                     input logic [19:0] wv, input logic [19:0] wp, input logic [1:0] wpr,
                     input bit fr);
    bus.lk_req    = lq;
    bus.lk_vpn    = lv;
    bus.wr_en     = we;
    bus.wr_way    = 2'(ww);
    bus.wr_vpn    = wv;
    bus.wr_ppn    = wp;
    bus.wr_perms  = wpr;
    bus.flush_req = fr;
    @(posedge clk);
    #1;
    bus.lk_req    = 1'b0;
    bus.wr_en     = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic lookup(input logic [19:0] v);
    cyc(1'b1, v, 1'b0, 0, '0, '0, '0, 1'b0);
  endtask

  task automatic write(input int w, input logic [19:0] v, input logic [19:0] p, input logic [1:0] pr);
    cyc(1'b0, '0, 1'b1, w, v, p, pr, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 0, '0, '0, '0, 1'b0);
  endtask

  task automatic expect_rsp(input string name, input bit hit, input int way,
                            input logic [19:0] ppn, input logic [1:0] perms);
    chk({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({name, "_hit"}, 32'(bus.rsp_hit), 32'(hit));
    chk({name, "_way"}, 32'(bus.rsp_way), way);
    chk({name, "_ppn"}, 32'(bus.rsp_ppn), 32'(ppn));
    chk({name, "_perms"}, 32'(bus.rsp_perms), 32'(perms));
  endtask

  initial begin
    int n;
    bus.lk_req = 1'b0; bus.lk_vpn = '0; bus.wr_en = 1'b0; bus.wr_way = '0;
    bus.wr_vpn = '0; bus.wr_ppn = '0; bus.wr_perms = '0; bus.flush_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_hit", 32'(bus.rsp_hit), 32'd0);
    chk("reset_rsp_way", 32'(bus.rsp_way), 32'd0);
    chk("reset_rsp_ppn", 32'(bus.rsp_ppn), 32'd0);
    chk("reset_flush_busy", 32'(bus.flush_busy), 32'd0);
    rst_n = 1'b1;
    idle();
    chk("ready_after_reset", 32'(bus.lk_ready & bus.wr_ready), 32'd1);

    lookup(20'h00013);
    expect_rsp("first_miss", 1'b0, 0, '0, '0);

    write(2, 20'h00013, 20'hABCDE, 2'b11);
    lookup(20'h00013);
    expect_rsp("hit_way2", 1'b1, 2, 20'hABCDE, 2'b11);

    write(0, 20'h00103, 20'h11111, 2'b01);
    write(1, 20'h00203, 20'h22222, 2'b10);
    write(3, 20'h00303, 20'h33333, 2'b11);
    for (int r = 0; r < 2; r++) begin
      lookup(20'h00103);
      lookup(20'h00203);
      lookup(20'h00303);
    end
    lookup(20'h00403);
    expect_rsp("lru_victim2", 1'b0, 2, '0, '0);
    chk("model_age_3_2", m_age[3][2], 7);
    for (int i = 0; i < 9; i++) lookup(20'h00103);
    chk("model_age_3_1", m_age[3][1], 7);
    lookup(20'h00403);
    expect_rsp("lru_victim1", 1'b0, 1, '0, '0);

    cyc(1'b1, 20'h00025, 1'b1, 1, 20'h00025, 20'h12345, 2'b01, 1'b0);
    expect_rsp("rbw_miss", 1'b0, 0, '0, '0);
    lookup(20'h00025);
    expect_rsp("rbw_hit", 1'b1, 1, 20'h12345, 2'b01);
    chk("model_age_5_1", m_age[5][1], 0);

    cyc(1'b1, 20'h00013, 1'b1, 2, 20'h00503, 20'h55555, 2'b10, 1'b0);
    expect_rsp("overwrite_old", 1'b1, 2, 20'hABCDE, 2'b11);
    lookup(20'h00013);
    chk("overwrite_gone", 32'(bus.rsp_hit), 32'd0);
    lookup(20'h00503);
    expect_rsp("overwrite_new", 1'b1, 2, 20'h55555, 2'b10);

    cyc(1'b1, 20'h00025, 1'b1, 0, 20'h00077, 20'h00777, 2'b01, 1'b0);
    expect_rsp("diffset_lk", 1'b1, 1, 20'h12345, 2'b01);
    lookup(20'h00077);
    expect_rsp("diffset_wr", 1'b1, 0, 20'h00777, 2'b01);

    cyc(1'b1, 20'h00025, 1'b0, 0, '0, '0, '0, 1'b1);
    expect_rsp("flush_take_rsp", 1'b1, 1, 20'h12345, 2'b01);
    chk("flush_take_busy", 32'(bus.flush_busy), 32'd1);
    n = 0;
    while (bus.flush_busy && n < 40) begin
      n++;
      chk("flush_lk_ready", 32'(bus.lk_ready), 32'd0);
      cyc(1'b1, 20'h00013, 1'b1, 3, 20'h00913, 20'h99999, 2'b00, 1'b1);
    end
    chk("flush_len", n, 16);
    lookup(20'h00503);
    expect_rsp("post_flush_a", 1'b0, 0, '0, '0);
    lookup(20'h00025);
    expect_rsp("post_flush_b", 1'b0, 0, '0, '0);
    lookup(20'h00077);
    expect_rsp("post_flush_c", 1'b0, 0, '0, '0);
    lookup(20'h00913);
    expect_rsp("post_flush_d", 1'b0, 0, '0, '0);

    write(0, 20'h00103, 20'h11111, 2'b01);
    write(1, 20'h0000C, 20'hCCCCC, 2'b00);
    cyc(1'b0, '0, 1'b0, 0, '0, '0, '0, 1'b1);
    repeat (4) idle();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.flush_busy), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    lookup(20'h00103);
    expect_rsp("abort_miss_a", 1'b0, 0, '0, '0);
    lookup(20'h0000C);
    expect_rsp("abort_miss_b", 1'b0, 0, '0, '0);

    write(0, 20'h0002A, 20'h0AAAA, 2'b01);
    for (int i = 0; i < 3; i++) lookup(20'h0002A);
    expect_rsp("stats_hit", 1'b1, 0, 20'h0AAAA, 2'b01);
    idle();
`ifdef TLB_STATS_EN
    chk("stat_hits_lit", stat_hits, 32'd3);
    chk("stat_misses_lit", stat_misses, 32'd2);
    lookup(20'h0003A);
    stat_clr = 1'b1;
    idle();
    stat_clr = 1'b0;
    chk("stat_clr_hits", stat_hits, 32'd0);
    chk("stat_clr_misses", stat_misses, 32'd0);
`endif
    idle();
    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tlb_storage_assoc.md
Name: tlb_storage_assoc

Overview:
- Parametrised successor to the fixed 4-way TLB storage array: N-way set-associative VPN->PPN store.
- Integrates tag compare with a registered lookup result.
- Uses saturating age-based LRU with victim selection and a sequenced flush engine.
- Sits between the TLB control FSM (lookup/refill/flush requests) and the page-walk refill path.

Parameters:
- NUM_SETS, 16, number of sets; power of two, >=2; SET_BITS = $clog2(NUM_SETS) derived.
- NUM_WAYS, 4, ways per set; power of two, >=2; WAY_BITS = $clog2(NUM_WAYS) derived.
- VPN_W, 20, virtual page number width.
- PPN_W, 20, physical page number width.
- PERM_W, 2, permission field width.
- AGE_W, 3, per-entry LRU age counter width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- lk_req  in  1  lookup request
- lk_ready  out  1  lookup accepted when lk_req & lk_ready
- lk_vpn  in  VPN_W  lookup VPN; set index = lk_vpn[SET_BITS-1:0]
- rsp_valid  out  1  lookup result valid (one-cycle pulse)
- rsp_hit  out  1  hit flag
- rsp_way  out  WAY_BITS  hit way, or victim way on miss
- rsp_ppn  out  PPN_W  PPN of hit entry; 0 on miss
- rsp_perms  out  PERM_W  perms of hit entry; 0 on miss
- wr_en  in  1  refill write
- wr_ready  out  1  write accepted when wr_en & wr_ready
- wr_way  in  WAY_BITS  target way, normally rsp_way from the preceding miss
- wr_vpn  in  VPN_W  VPN; the set index is derived from it
- wr_ppn  in  PPN_W  PPN
- wr_perms  in  PERM_W  permissions
- flush_req  in  1  invalidate-all request, sampled in IDLE only
- flush_busy  out  1  high while a flush is in progress

Behaviour:
- Reset:
  - All valid bits and ages clear; FSM goes to IDLE.
  - rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_ppn=0, rsp_perms=0, flush_busy=0.
  - lk_ready=1 and wr_ready=1 once reset deasserts.
  - VPN/PPN/perm arrays are not reset.
- Tag stored: full VPN; compare against full lk_vpn.
- Lookup latency 1:
  - An accepted request in cycle N produces rsp_* valid in cycle N+1.
  - A request is accepted every cycle; rsp_valid is high only in the cycle after acceptance.
- Hit: exactly one valid way with a matching tag gives rsp_hit=1 and rsp_way = that way.
  - Multiple matches are a software error; the lowest-index way wins.
- Miss: rsp_hit=0; rsp_way = victim:
  - lowest-index invalid way if any exists;
  - otherwise the way with the maximum age, ties broken by lowest index.
- LRU update, applied at the edge that registers the lookup:
  - On hit: the hit way's age becomes 0.
  - Every other valid way in the set increments, saturating at 2^AGE_W-1.
  - A miss leaves ages unchanged.
- Write:
  - Sets valid=1 and loads vpn/ppn/perms for the entry.
  - The written way's age becomes 0; other valid ways in the set increment (saturating).
- Same-cycle lookup and write, same set:
  - The lookup sees pre-write contents (read-before-write).
  - Ages: the written way ends at 0; other valid ways increment once, not twice.
  - A lookup hit on the written way is overridden by the write.
- Same-cycle lookup and write, different sets: both take effect independently.
- FSM IDLE -> FLUSH:
  - Taken on flush_req in IDLE; flush_busy=1 from the next cycle.
  - FLUSH clears valid and age of set flush_idx, one set per cycle, idx 0..NUM_SETS-1.
  - After the last set the FSM returns to IDLE; the flush occupies exactly NUM_SETS cycles.
  - flush_req asserted during FLUSH is ignored (not queued).
- During FLUSH:
  - lk_ready=0 and wr_ready=0.
  - A lookup accepted in the cycle flush_req is taken still returns its response next cycle.
- Reset asserted mid-flush aborts the flush: all valid bits clear immediately and the FSM returns to IDLE.

Optional Feature:
- Macro TLB_STATS_EN.
- Defined:
  - Adds outputs stat_hits[31:0] and stat_misses[31:0] and input stat_clr.
  - The counters increment on each rsp_valid with hit/miss respectively and wrap modulo 2^32.
  - stat_clr zeroes both synchronously and has priority over increment.
  - Both counters are reset to 0 by rst_n.
- Undefined: the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset then lookup vpn=0x00013 -> next cycle rsp_valid=1, rsp_hit=0, rsp_way=0.
- Write way 2 vpn=0x00013 ppn=0xABCDE perms=2'b11, then lookup 0x00013 -> rsp_hit=1, rsp_way=2, rsp_ppn=0xABCDE, rsp_perms=2'b11.
- Fill all 4 ways of set 3, hit ways 0, 1, 3 repeatedly, then miss in set 3 -> rsp_way=2. With AGE_W=3, 9 hits on way 0 -> way 1 age saturates at 7.
- Write and lookup of the same VPN in the same cycle -> lookup reports a miss; the following lookup hits with the written way at age 0.
- flush_req with NUM_SETS=16 -> flush_busy high for exactly 16 cycles, lk_ready low throughout, then all lookups miss.
- Assert rst_n low at flush cycle 5 -> flush_busy=0 and all entries invalid after release; with TLB_STATS_EN, 3 hits and 2 misses give stat_hits=3 and stat_misses=2.
